// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the decoder / control-pipeline boundary of the
// 5-stage MIPS core.
//   - Bit positions of the fields inside the 32-bit decoder control word.
//   - Encodings of the ALU operand forwarding selects.
//   - Primary opcodes, shared with the main decoder so both sides agree on
//     which instruction classes exist.
// ---------------------------------------------------------------------------
package ctrl_pkg;

   // Control-word bit positions. ALUOp occupies ALUOP_HI:ALUOP_LO.
   localparam int ALUSRC    = 0;
   localparam int ALUOP_LO  = 1;
   localparam int ALUOP_HI  = 2;
   localparam int REGDST    = 3;
   localparam int MEMREAD   = 4;
   localparam int MEMWRITE  = 5;
   localparam int REGWRITE  = 6;
   localparam int MEMTOREG  = 7;
   localparam int JUMP      = 8;
   localparam int BRANCH    = 9;

   // Number of meaningful low-order control-word bits; everything above is
   // ignored by the pipeline.
   localparam int CTRL_USED = 10;

   // ALU operand source selects.
   localparam logic [1:0] FWD_REG   = 2'b00;  // register file read data
   localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM ALU result
   localparam logic [1:0] FWD_MEMWB = 2'b01;  // MEM/WB write-back data

   // Primary opcodes (instr[31:26]).
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/ctrl_pipe_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Combinational EX-stage forwarding selects for both ALU operands.
// A younger producer (EX/MEM) wins over an older one (MEM/WB); register $0
// is hard-wired to zero and is never forwarded.
//
// Ports:
//   exmem_regwrite_i  EX/MEM RegWrite
//   exmem_wreg_i      EX/MEM destination register
//   memwb_regwrite_i  MEM/WB RegWrite
//   memwb_wreg_i      MEM/WB destination register
//   idex_rs_i         ID/EX rs (operand A source)
//   idex_rt_i         ID/EX rt (operand B source)
//   fwd_a_o           operand A select (FWD_REG / FWD_EXMEM / FWD_MEMWB)
//   fwd_b_o           operand B select, same encoding
// ---------------------------------------------------------------------------
module fwd_unit
   import ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             exmem_regwrite_i,
   input  logic [REG_W-1:0] exmem_wreg_i,
   input  logic             memwb_regwrite_i,
   input  logic [REG_W-1:0] memwb_wreg_i,
   input  logic [REG_W-1:0] idex_rs_i,
   input  logic [REG_W-1:0] idex_rt_i,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o
);

   // A stage is a live producer only if it writes a register other than $0.
   logic exmem_live;
   logic memwb_live;

   always_comb begin
      exmem_live = exmem_regwrite_i & (exmem_wreg_i != '0);
      memwb_live = memwb_regwrite_i & (memwb_wreg_i != '0);

      fwd_a_o = FWD_REG;
      if (exmem_live && (exmem_wreg_i == idex_rs_i)) begin
         fwd_a_o = FWD_EXMEM;
      end else if (memwb_live && (memwb_wreg_i == idex_rs_i)) begin
         fwd_a_o = FWD_MEMWB;
      end

      fwd_b_o = FWD_REG;
      if (exmem_live && (exmem_wreg_i == idex_rt_i)) begin
         fwd_b_o = FWD_EXMEM;
      end else if (memwb_live && (memwb_wreg_i == idex_rt_i)) begin
         fwd_b_o = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
// Consumer end of the main decoder's control-word interface. Carries the
// EX/MEM/WB control fields through the ID/EX, EX/MEM and MEM/WB pipeline
// registers and generates load-use stall, branch/jump flush and EX-stage
// forwarding selects for the 5-stage MIPS datapath.
//
// Timing: ctrl_i sampled on edge n is visible on ex_* after edge n, on
// mem_* after edge n+1 and on wb_* after edge n+2. Nothing beyond ID can be
// held; the only hold is stall_o, which freezes PC and IF/ID while this
// block inserts a bubble into ID/EX.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   ctrl_i          decoder control word (bits CTRL_USED-1:0 meaningful)
//   rs_i/rt_i/rd_i  ID-stage register fields
//   eq_i            ID-stage register comparator (rs == rt)
//   ex_alusrc_o     ID/EX ALUSrc
//   ex_aluop_o      ID/EX ALUOp
//   ex_wreg_o       EX destination register (rd if RegDst else rt)
//   mem_memread_o   EX/MEM MemRead
//   mem_memwrite_o  EX/MEM MemWrite
//   wb_regwrite_o   MEM/WB RegWrite
//   wb_memtoreg_o   MEM/WB MemToReg
//   wb_wreg_o       MEM/WB write register index
//   fwd_a_o/fwd_b_o ALU operand selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   stall_o         hold PC and IF/ID (combinational)
//   flush_o         zero IF/ID (combinational)
// ---------------------------------------------------------------------------
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter int CTRL_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [REG_W-1:0]  rs_i,
   input  logic [REG_W-1:0]  rt_i,
   input  logic [REG_W-1:0]  rd_i,
   input  logic              eq_i,
   output logic              ex_alusrc_o,
   output logic [1:0]        ex_aluop_o,
   output logic [REG_W-1:0]  ex_wreg_o,
   output logic              mem_memread_o,
   output logic              mem_memwrite_o,
   output logic              wb_regwrite_o,
   output logic              wb_memtoreg_o,
   output logic [REG_W-1:0]  wb_wreg_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              stall_o,
   output logic              flush_o
);

   // ---------------- ID/EX ----------------
   logic             idex_alusrc_q,   idex_alusrc_d;
   logic [1:0]       idex_aluop_q,    idex_aluop_d;
   logic             idex_regdst_q,   idex_regdst_d;
   logic             idex_memread_q,  idex_memread_d;
   logic             idex_memwrite_q, idex_memwrite_d;
   logic             idex_regwrite_q, idex_regwrite_d;
   logic             idex_memtoreg_q, idex_memtoreg_d;
   logic [REG_W-1:0] idex_rs_q,       idex_rs_d;
   logic [REG_W-1:0] idex_rt_q,       idex_rt_d;
   logic [REG_W-1:0] idex_rd_q,       idex_rd_d;

   // ---------------- EX/MEM ---------------
   logic             exmem_memread_q,  exmem_memread_d;
   logic             exmem_memwrite_q, exmem_memwrite_d;
   logic             exmem_regwrite_q, exmem_regwrite_d;
   logic             exmem_memtoreg_q, exmem_memtoreg_d;
   logic [REG_W-1:0] exmem_wreg_q,     exmem_wreg_d;

   // ---------------- MEM/WB ---------------
   logic             memwb_regwrite_q, memwb_regwrite_d;
   logic             memwb_memtoreg_q, memwb_memtoreg_d;
   logic [REG_W-1:0] memwb_wreg_q,     memwb_wreg_d;

   logic             stall;
   logic             flush;
   logic [REG_W-1:0] ex_wreg;

   // Upper control-word bits are reserved by the decoder and deliberately
   // not consumed here.
   logic unused_ctrl_bits;
   assign unused_ctrl_bits = ^ctrl_i[CTRL_W-1:CTRL_USED];

   always_comb begin
      // Load-use: the load in EX produces its data too late for the
      // instruction now in ID. One bubble is enough because the bubble
      // clears idex_memread_q on the next edge.
      stall = idex_memread_q & ((idex_rt_q == rs_i) | (idex_rt_q == rt_i));

      // A stalled branch must not redirect yet; it re-evaluates next cycle
      // once its operands can be forwarded.
      flush = ~stall & (ctrl_i[JUMP] | (ctrl_i[BRANCH] & eq_i));

      ex_wreg = idex_regdst_q ? idex_rd_q : idex_rt_q;

      // ID/EX: control from the decoder, or all-zero control on a bubble.
      // jump/branch are resolved in ID and never enter ID/EX.
      idex_alusrc_d   = ctrl_i[ALUSRC];
      idex_aluop_d    = ctrl_i[ALUOP_HI:ALUOP_LO];
      idex_regdst_d   = ctrl_i[REGDST];
      idex_memread_d  = ctrl_i[MEMREAD];
      idex_memwrite_d = ctrl_i[MEMWRITE];
      idex_regwrite_d = ctrl_i[REGWRITE];
      idex_memtoreg_d = ctrl_i[MEMTOREG];
      if (stall) begin
         idex_alusrc_d   = 1'b0;
         idex_aluop_d    = 2'b00;
         idex_regdst_d   = 1'b0;
         idex_memread_d  = 1'b0;
         idex_memwrite_d = 1'b0;
         idex_regwrite_d = 1'b0;
         idex_memtoreg_d = 1'b0;
      end
      // Register fields load even during a bubble; with zero control they
      // are harmless.
      idex_rs_d = rs_i;
      idex_rt_d = rt_i;
      idex_rd_d = rd_i;

      // EX/MEM and MEM/WB always advance.
      exmem_memread_d  = idex_memread_q;
      exmem_memwrite_d = idex_memwrite_q;
      exmem_regwrite_d = idex_regwrite_q;
      exmem_memtoreg_d = idex_memtoreg_q;
      exmem_wreg_d     = ex_wreg;

      memwb_regwrite_d = exmem_regwrite_q;
      memwb_memtoreg_d = exmem_memtoreg_q;
      memwb_wreg_d     = exmem_wreg_q;
   end

   // Reset discards everything in flight and takes priority over a stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idex_alusrc_q    <= 1'b0;
         idex_aluop_q     <= 2'b00;
         idex_regdst_q    <= 1'b0;
         idex_memread_q   <= 1'b0;
         idex_memwrite_q  <= 1'b0;
         idex_regwrite_q  <= 1'b0;
         idex_memtoreg_q  <= 1'b0;
         idex_rs_q        <= '0;
         idex_rt_q        <= '0;
         idex_rd_q        <= '0;
         exmem_memread_q  <= 1'b0;
         exmem_memwrite_q <= 1'b0;
         exmem_regwrite_q <= 1'b0;
         exmem_memtoreg_q <= 1'b0;
         exmem_wreg_q     <= '0;
         memwb_regwrite_q <= 1'b0;
         memwb_memtoreg_q <= 1'b0;
         memwb_wreg_q     <= '0;
      end else begin
         idex_alusrc_q    <= idex_alusrc_d;
         idex_aluop_q     <= idex_aluop_d;
         idex_regdst_q    <= idex_regdst_d;
         idex_memread_q   <= idex_memread_d;
         idex_memwrite_q  <= idex_memwrite_d;
         idex_regwrite_q  <= idex_regwrite_d;
         idex_memtoreg_q  <= idex_memtoreg_d;
         idex_rs_q        <= idex_rs_d;
         idex_rt_q        <= idex_rt_d;
         idex_rd_q        <= idex_rd_d;
         exmem_memread_q  <= exmem_memread_d;
         exmem_memwrite_q <= exmem_memwrite_d;
         exmem_regwrite_q <= exmem_regwrite_d;
         exmem_memtoreg_q <= exmem_memtoreg_d;
         exmem_wreg_q     <= exmem_wreg_d;
         memwb_regwrite_q <= memwb_regwrite_d;
         memwb_memtoreg_q <= memwb_memtoreg_d;
         memwb_wreg_q     <= memwb_wreg_d;
      end
   end

   // Forwarding looks at current EX contents regardless of stall.
   fwd_unit #(
      .REG_W (REG_W)
   ) u_fwd_unit (
      .exmem_regwrite_i (exmem_regwrite_q),
      .exmem_wreg_i     (exmem_wreg_q),
      .memwb_regwrite_i (memwb_regwrite_q),
      .memwb_wreg_i     (memwb_wreg_q),
      .idex_rs_i        (idex_rs_q),
      .idex_rt_i        (idex_rt_q),
      .fwd_a_o          (fwd_a_o),
      .fwd_b_o          (fwd_b_o)
   );

   assign ex_alusrc_o    = idex_alusrc_q;
   assign ex_aluop_o     = idex_aluop_q;
   assign ex_wreg_o      = ex_wreg;
   assign mem_memread_o  = exmem_memread_q;
   assign mem_memwrite_o = exmem_memwrite_q;
   assign wb_regwrite_o  = memwb_regwrite_q;
   assign wb_memtoreg_o  = memwb_memtoreg_q;
   assign wb_wreg_o      = memwb_wreg_q;
   assign stall_o        = stall;
   assign flush_o        = flush;

endmodule

// File: tb/tb_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe
// Directed bench for ctrl_pipe. Expected values are hand-derived from the
// control-word bit map:
//   0x4D : ALUSrc, ALUOp=10, RegDst, RegWrite
//   0x4C : R-type add (ALUOp=10, RegDst, RegWrite)
//   0xD1 : lw (ALUSrc, MemRead, RegWrite, MemToReg)
//   0x202: beq (ALUOp=01, branch)      0x100: j
// ---------------------------------------------------------------------------
module tb_ctrl_pipe;

   localparam int REG_W  = 5;
   localparam int CTRL_W = 32;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   logic [CTRL_W-1:0] ctrl_i;
   logic [REG_W-1:0]  rs_i, rt_i, rd_i;
   logic              eq_i;
   logic              ex_alusrc_o;
   logic [1:0]        ex_aluop_o;
   logic [REG_W-1:0]  ex_wreg_o;
   logic              mem_memread_o, mem_memwrite_o;
   logic              wb_regwrite_o, wb_memtoreg_o;
   logic [REG_W-1:0]  wb_wreg_o;
   logic [1:0]        fwd_a_o, fwd_b_o;
   logic              stall_o, flush_o;

   ctrl_pipe #(
      .REG_W  (REG_W),
      .CTRL_W (CTRL_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ctrl_i         (ctrl_i),
      .rs_i           (rs_i),
      .rt_i           (rt_i),
      .rd_i           (rd_i),
      .eq_i           (eq_i),
      .ex_alusrc_o    (ex_alusrc_o),
      .ex_aluop_o     (ex_aluop_o),
      .ex_wreg_o      (ex_wreg_o),
      .mem_memread_o  (mem_memread_o),
      .mem_memwrite_o (mem_memwrite_o),
      .wb_regwrite_o  (wb_regwrite_o),
      .wb_memtoreg_o  (wb_memtoreg_o),
      .wb_wreg_o      (wb_wreg_o),
      .fwd_a_o        (fwd_a_o),
      .fwd_b_o        (fwd_b_o),
      .stall_o        (stall_o),
      .flush_o        (flush_o)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [REG_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after a rising edge; outputs are checked
   // after a further 1 time unit, well away from the next edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [31:0] c, input int rs, input int rt, input int rd, input int eq);
      ctrl_i = c;
      rs_i   = REG_W'(rs);
      rt_i   = REG_W'(rt);
      rd_i   = REG_W'(rd);
      eq_i   = (eq != 0);
      #1;
   endtask

   task automatic nops(input int n);
      drive(32'h0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset held two cycles with a live control word on the input.
      rst_i = 1'b1;
      drive(32'h4D, 1, 2, 3, 0);
      tick();
      tick();
      check("rst_ex_alusrc",   32'(ex_alusrc_o),    0);
      check("rst_ex_aluop",    32'(ex_aluop_o),     0);
      check("rst_ex_wreg",     32'(ex_wreg_o),      0);
      check("rst_mem_memread", 32'(mem_memread_o),  0);
      check("rst_mem_memwr",   32'(mem_memwrite_o), 0);
      check("rst_wb_regwrite", 32'(wb_regwrite_o),  0);
      check("rst_wb_memtoreg", 32'(wb_memtoreg_o),  0);
      check("rst_wb_wreg",     32'(wb_wreg_o),      0);
      check("rst_fwd_a",       32'(fwd_a_o),        0);
      check("rst_fwd_b",       32'(fwd_b_o),        0);
      check("rst_stall",       32'(stall_o),        0);
      check("rst_flush",       32'(flush_o),        0);

      // Release: 0x4D enters EX on the next edge and reaches WB two later.
      rst_i = 1'b0;
      tick();
      check("rel_ex_aluop",  32'(ex_aluop_o),  2);
      check("rel_ex_alusrc", 32'(ex_alusrc_o), 1);
      check("rel_ex_wreg",   32'(ex_wreg_o),   3);
      drive(32'h0, 0, 0, 0, 0);
      tick();
      check("lat_ex_aluop_nop", 32'(ex_aluop_o),    0);
      check("lat_mem_memread",  32'(mem_memread_o), 0);
      tick();
      check("lat_wb_regwrite", 32'(wb_regwrite_o), 1);
      check("lat_wb_wreg",     32'(wb_wreg_o),     3);
      check("lat_wb_memtoreg", 32'(wb_memtoreg_o), 0);

      // Back-to-back adds: each destination must appear on wb_wreg_o
      // in issue order, three edges after issue.
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            drive(32'h4C, 0, 0, 12 + k, 0);
            exp_q.push_back(REG_W'(12 + k));
         end else begin
            drive(32'h0, 0, 0, 0, 0);
         end
         tick();
         if (k >= 2) begin
            check("sb_wb_regwrite", 32'(wb_regwrite_o), 1);
            check("sb_wb_wreg", 32'(wb_wreg_o), 32'(exp_q.pop_front()));
         end
      end
      check("sb_queue_empty", 32'(exp_q.size()), 0);

      // Load-use: lw $8 then add using $8.
      nops(3);
      drive(32'hD1, 1, 8, 0, 0);
      tick();
      drive(32'h4C, 8, 9, 10, 0);
      check("lu_stall_on",  32'(stall_o), 1);
      check("lu_flush_off", 32'(flush_o), 0);
      tick();
      check("lu_stall_once",   32'(stall_o),       0);
      check("lu_bubble_aluop", 32'(ex_aluop_o),    0);
      check("lu_bubble_alusrc",32'(ex_alusrc_o),   0);
      check("lu_bubble_wreg",  32'(ex_wreg_o),     9);
      check("lu_mem_memread",  32'(mem_memread_o), 1);
      tick();
      check("lu_add_aluop",    32'(ex_aluop_o),    2);
      check("lu_add_wreg",     32'(ex_wreg_o),     10);
      check("lu_fwd_a_memwb",  32'(fwd_a_o),       1);
      check("lu_fwd_b_none",   32'(fwd_b_o),       0);
      check("lu_wb_memtoreg",  32'(wb_memtoreg_o), 1);
      check("lu_wb_wreg",      32'(wb_wreg_o),     8);
      check("lu_mem_bubble",   32'(mem_memread_o), 0);

      // Forward priority: two producers of $3, EX/MEM wins.
      nops(3);
      drive(32'h4C, 1, 2, 3, 0);
      tick();
      drive(32'h4C, 4, 5, 3, 0);
      tick();
      drive(32'h4C, 3, 6, 7, 0);
      tick();
      check("fw_prio_a", 32'(fwd_a_o), 2);
      check("fw_prio_b", 32'(fwd_b_o), 0);

      // Producer, nop, consumer on operand B -> MEM/WB.
      nops(3);
      drive(32'h4C, 1, 2, 3, 0);
      tick();
      drive(32'h0, 0, 0, 0, 0);
      tick();
      drive(32'h4C, 11, 3, 7, 0);
      tick();
      check("fw_memwb_b", 32'(fwd_b_o), 1);
      check("fw_memwb_a", 32'(fwd_a_o), 0);

      // Producer writing $0 is never forwarded.
      nops(3);
      drive(32'h4C, 1, 2, 0, 0);
      tick();
      drive(32'h4C, 0, 0, 5, 0);
      tick();
      check("fw_r0_a", 32'(fwd_a_o), 0);
      check("fw_r0_b", 32'(fwd_b_o), 0);

      // Branch / jump flush.
      nops(1);
      drive(32'h202, 1, 2, 0, 1);
      check("br_taken", 32'(flush_o), 1);
      drive(32'h202, 1, 2, 0, 0);
      check("br_not_taken", 32'(flush_o), 0);
      drive(32'h100, 0, 0, 0, 0);
      check("jmp_eq0", 32'(flush_o), 1);
      drive(32'h100, 0, 0, 0, 1);
      check("jmp_eq1", 32'(flush_o), 1);

      // Upper control bits are ignored.
      drive(32'hFFFF_FC00, 0, 0, 0, 1);
      check("hi_bits_flush", 32'(flush_o), 0);
      drive(32'hFFFF_FC4D, 1, 2, 3, 0);
      tick();
      check("hi_bits_aluop",  32'(ex_aluop_o),     2);
      check("hi_bits_wreg",   32'(ex_wreg_o),      3);
      check("hi_bits_alusrc", 32'(ex_alusrc_o),    1);
      tick();
      check("hi_bits_memrd",  32'(mem_memread_o),  0);
      check("hi_bits_memwr",  32'(mem_memwrite_o), 0);

      // Branch behind load: stall first, flush one cycle later.
      nops(3);
      drive(32'hD1, 1, 5, 0, 0);
      tick();
      drive(32'h202, 5, 6, 0, 1);
      check("bl_stall",    32'(stall_o), 1);
      check("bl_no_flush", 32'(flush_o), 0);
      tick();
      check("bl_stall_off", 32'(stall_o), 0);
      check("bl_flush",     32'(flush_o), 1);

      // Reset mid-flight with a load in EX/MEM and a stall pending.
      nops(3);
      drive(32'hD1, 1, 5, 0, 0);
      tick();
      drive(32'hD1, 1, 6, 0, 0);
      tick();
      drive(32'h4C, 6, 9, 10, 0);
      check("mr_pre_memread", 32'(mem_memread_o), 1);
      check("mr_pre_stall",   32'(stall_o),       1);
      rst_i = 1'b1;
      tick();
      check("mr_mem_memread", 32'(mem_memread_o), 0);
      check("mr_wb_regwrite", 32'(wb_regwrite_o), 0);
      check("mr_fwd_a",       32'(fwd_a_o),       0);
      check("mr_fwd_b",       32'(fwd_b_o),       0);
      check("mr_ex_wreg",     32'(ex_wreg_o),     0);
      check("mr_stall",       32'(stall_o),       0);
      rst_i = 1'b0;
      tick();

      // ---------------- report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
